ir_nec_receiver: RTL and testbench

Pulse-width decoder for an active-low demodulated IR receiver output, decoding NEC-format frames (leader, 32 data bits LSB-first, stop mark). It sits directly upstream of the IR read-control state machine. It is armed by that machine's `read` request and answers with a one-cycle `DONE` on a good frame or `ERROR` on any timing or checksum violation. The decoded 32-bit word is held on `data` for downstream consumers.

---
 rtl/ir_nec_receiver_pkg.sv | 46 ++++
 rtl/ir_nec_receiver_sync_edge.sv | 46 ++++
 rtl/ir_nec_receiver.sv | 232 +++++++++++++++++++++++
 tb/tb_ir_nec_receiver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_receiver_pkg.sv
// ---------------------------------------------------------------------------
// ir_pkg
// Shared definitions for the NEC IR receiver:
//   - ir_state_t   : receiver FSM state encoding
//   - WIDTH_W      : width of the pulse-width counter in microsecond ticks
//   - *_US         : inclusive pulse-width windows in microseconds
//   - in_window()  : inclusive range test on a measured width
// ---------------------------------------------------------------------------
package ir_pkg;

    localparam int unsigned WIDTH_W = 14;
    localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;

    // Inclusive windows, microseconds.
    localparam int unsigned LEAD_MARK_MIN_US  = 8000;
    localparam int unsigned LEAD_MARK_MAX_US  = 10000;
    localparam int unsigned LEAD_SPACE_MIN_US = 4000;
    localparam int unsigned LEAD_SPACE_MAX_US = 5000;
    localparam int unsigned BIT_MARK_MIN_US   = 400;
    localparam int unsigned BIT_MARK_MAX_US   = 750;
    localparam int unsigned ZERO_SPACE_MIN_US = 400;
    localparam int unsigned ZERO_SPACE_MAX_US = 750;
    localparam int unsigned ONE_SPACE_MIN_US  = 1400;
    localparam int unsigned ONE_SPACE_MAX_US  = 1900;
    localparam int unsigned STOP_MARK_MIN_US  = 400;
    localparam int unsigned STOP_MARK_MAX_US  = 750;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ARMED      = 4'd1,
        S_LEAD_MARK  = 4'd2,
        S_LEAD_SPACE = 4'd3,
        S_BIT_MARK   = 4'd4,
        S_BIT_SPACE  = 4'd5,
        S_STOP       = 4'd6,
        S_DONE       = 4'd7,
        S_ERROR      = 4'd8
    } ir_state_t;

    function automatic logic in_window(input logic [WIDTH_W-1:0] w,
                                       input logic [WIDTH_W-1:0] lo,
                                       input logic [WIDTH_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_nec_receiver_sync_edge.sv
// ---------------------------------------------------------------------------
// ir_sync_edge
// Two-flop synchronizer for the asynchronous IR line followed by a registered
// edge detector. All flops reset to the idle-high line level so no edge is
// reported coming out of reset. Input-to-pulse latency is 3 clock cycles.
// Ports:
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset
//   ir_i    in   raw asynchronous IR line (low = mark)
//   rise_o  out  one-cycle pulse: synchronized line went low->high
//   fall_o  out  one-cycle pulse: synchronized line went high->low
// ---------------------------------------------------------------------------
module ir_sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic ir_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic prev_q;
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= ir_i;
            s2_q   <= s1_q;
            prev_q <= s2_q;
            rise_q <= s2_q & ~prev_q;
            fall_q <= ~s2_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/ir_nec_receiver.sv
// ---------------------------------------------------------------------------
// ir_nec_receiver
// NEC IR frame decoder (leader, 32 data bits LSB first, stop mark) for an
// active-low demodulated receiver output. Armed by `read`, answers with a
// one-cycle DONE (frame good, `data` updated in the same cycle) or ERROR.
//
// Optional feature macro: IR_NEC_CHECK_EN -- when defined, the stop mark is
// only accepted if the command byte matches its inverse (shift[31:24] ==
// ~shift[23:16]); otherwise any timing-valid frame is accepted.
//
// Parameters:
//   CLKS_PER_US     clock cycles per 1 us tick
//   TIMEOUT_US      longest mark/space tolerated while a frame is in progress
//   TIME_SCALE_DIV  divides every us window and the timeout; 1 for real IR
//                   timing, larger values compress frames for fast simulation
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   ir_in        in   raw IR line, idle high, low = mark
//   read         in   arm request (level)
//   DONE         out  one-cycle pulse, good frame
//   ERROR        out  one-cycle pulse, frame aborted
//   data         out  last good frame {~cmd, cmd, ~addr, addr}
//   busy         out  high outside IDLE/ARMED
//   dbg_state_o  out  current FSM state
// ---------------------------------------------------------------------------
module ir_nec_receiver
    import ir_pkg::*;
#(
    parameter int unsigned CLKS_PER_US    = 50,
    parameter int unsigned TIMEOUT_US     = 12000,
    parameter int unsigned TIME_SCALE_DIV = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ir_in,
    input  logic        read,
    output logic        DONE,
    output logic        ERROR,
    output logic [31:0] data,
    output logic        busy,
    output ir_state_t   dbg_state_o
);

    // Windows expressed in ticks of the width counter.
    localparam logic [WIDTH_W-1:0] LM_LO = WIDTH_W'(LEAD_MARK_MIN_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] LM_HI = WIDTH_W'(LEAD_MARK_MAX_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] LS_LO = WIDTH_W'(LEAD_SPACE_MIN_US / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] LS_HI = WIDTH_W'(LEAD_SPACE_MAX_US / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] BM_LO = WIDTH_W'(BIT_MARK_MIN_US   / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] BM_HI = WIDTH_W'(BIT_MARK_MAX_US   / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] B0_LO = WIDTH_W'(ZERO_SPACE_MIN_US / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] B0_HI = WIDTH_W'(ZERO_SPACE_MAX_US / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] B1_LO = WIDTH_W'(ONE_SPACE_MIN_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] B1_HI = WIDTH_W'(ONE_SPACE_MAX_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] SM_LO = WIDTH_W'(STOP_MARK_MIN_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] SM_HI = WIDTH_W'(STOP_MARK_MAX_US  / TIME_SCALE_DIV);
    localparam logic [WIDTH_W-1:0] TIMEOUT_TICKS = WIDTH_W'(TIMEOUT_US / TIME_SCALE_DIV);

    localparam logic [15:0] PRESC_LAST = 16'(CLKS_PER_US - 1);

    // ------------------------------------------------------------------
    // Line conditioning
    // ------------------------------------------------------------------
    logic rise;
    logic fall;
    logic any_edge;

    ir_sync_edge u_sync_edge (
        .clk_i  (clk),
        .rst_ni (reset),
        .ir_i   (ir_in),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign any_edge = rise | fall;

    // ------------------------------------------------------------------
    // Microsecond prescaler and width counter. The prescaler free-runs, so
    // a measured width can be off by one tick depending on its phase.
    // ------------------------------------------------------------------
    logic [15:0]        presc_q;
    logic               tick;
    logic [WIDTH_W-1:0] width_q;

    assign tick = (presc_q == PRESC_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
            width_q <= '0;
        end else begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
            if (any_edge) begin
                width_q <= '0;
            end else if (tick && (width_q != WIDTH_MAX)) begin
                width_q <= width_q + 1'b1;
            end
        end
    end

    logic time_up;
    assign time_up = (width_q >= TIMEOUT_TICKS);

    // ------------------------------------------------------------------
    // Checksum on the command byte pair
    // ------------------------------------------------------------------
    logic [31:0] shift_q, shift_d;
    logic        chk_ok;

`ifdef IR_NEC_CHECK_EN
    assign chk_ok = (shift_q[31:24] == ~shift_q[23:16]);
`else
    assign chk_ok = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    ir_state_t   state_q, state_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] data_q, data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        data_d  = data_q;

        unique case (state_q)
            S_IDLE: begin
                if (read) state_d = S_ARMED;
            end

            S_ARMED: begin
                // A starting frame wins over a simultaneous disarm.
                if (fall) begin
                    state_d = S_LEAD_MARK;
                    shift_d = '0;
                    idx_d   = '0;
                end else if (!read) begin
                    state_d = S_IDLE;
                end
            end

            S_LEAD_MARK: begin
                if (rise) begin
                    state_d = in_window(width_q, LM_LO, LM_HI) ? S_LEAD_SPACE : S_ERROR;
                end else if (time_up) begin
                    state_d = S_ERROR;
                end
            end

            S_LEAD_SPACE: begin
                if (fall) begin
                    if (in_window(width_q, LS_LO, LS_HI)) begin
                        state_d = S_BIT_MARK;
                        idx_d   = '0;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (time_up) begin
                    state_d = S_ERROR;
                end
            end

            S_BIT_MARK: begin
                if (rise) begin
                    state_d = in_window(width_q, BM_LO, BM_HI) ? S_BIT_SPACE : S_ERROR;
                end else if (time_up) begin
                    state_d = S_ERROR;
                end
            end

            S_BIT_SPACE: begin
                // The fall that ends the 32nd space starts the stop mark, so
                // that mark is timed in STOP rather than as another bit mark.
                if (fall) begin
                    if (in_window(width_q, B0_LO, B0_HI) || in_window(width_q, B1_LO, B1_HI)) begin
                        shift_d = {in_window(width_q, B1_LO, B1_HI), shift_q[31:1]};
                        idx_d   = idx_q + 6'd1;
                        state_d = (idx_q == 6'd31) ? S_STOP : S_BIT_MARK;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (time_up) begin
                    state_d = S_ERROR;
                end
            end

            S_STOP: begin
                if (rise) begin
                    if (in_window(width_q, SM_LO, SM_HI) && chk_ok) begin
                        state_d = S_DONE;
                        data_d  = shift_q;
                    end else begin
                        state_d = S_ERROR;
                    end
                end else if (time_up) begin
                    state_d = S_ERROR;
                end
            end

            S_DONE:  state_d = S_IDLE;
            S_ERROR: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign DONE        = (state_q == S_DONE);
    assign ERROR       = (state_q == S_ERROR);
    assign busy        = (state_q != S_IDLE) && (state_q != S_ARMED);
    assign data        = data_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ir_nec_receiver.sv
module tb_ir_nec_receiver;
    import ir_pkg::*;

    // Durations in clock cycles; with CLKS_PER_US=1 and TIME_SCALE_DIV=10
    // one cycle stands for 10 us of real IR timing.
    localparam int LM = 900;
    localparam int LS = 450;
    localparam int BM = 56;
    localparam int B0 = 56;
    localparam int B1 = 169;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        ir_in = 1'b1;
    logic        read  = 1'b0;
    logic        DONE;
    logic        ERROR;
    logic [31:0] data;
    logic        busy;
    ir_state_t   dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int evt_count = 0;
    int last_evt_cyc = 0;
    logic busy_seen = 1'b0;
    logic watch_busy = 1'b0;
    logic [32:0] exp_q[$];
    logic [31:0] last_good = 32'h0;

    ir_nec_receiver #(
        .CLKS_PER_US    (1),
        .TIMEOUT_US     (12000),
        .TIME_SCALE_DIV (10)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ir_in       (ir_in),
        .read        (read),
        .DONE        (DONE),
        .ERROR       (ERROR),
        .data        (data),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every DONE/ERROR pulse pops one expected {error, data}.
    task automatic monitor_loop();
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            if (watch_busy && busy) busy_seen = 1'b1;
            if (DONE || ERROR) begin
                evt_count++;
                last_evt_cyc = cyc;
                chk("pulse_exclusive", 33'(DONE & ERROR), 33'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got ERROR=%b DONE=%b data=%h, required no event",
                             ERROR, DONE, data);
                end else begin
                    exp = exp_q.pop_front();
                    chk("event_kind_data", {ERROR, data}, exp);
                end
            end
        end
    endtask

    // Driver tasks
    task automatic drive(input logic lvl, input int n);
        ir_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [31:0] w, input int nbits, input bit do_stop, input int gap);
        drive(1'b0, LM);
        drive(1'b1, LS);
        for (int i = 0; i < nbits; i++) begin
            drive(1'b0, BM);
            drive(1'b1, w[i] ? B1 : B0);
        end
        if (do_stop) drive(1'b0, BM);
        drive(1'b1, gap);
    endtask

    initial begin : main
        int c0;
        int n0;
        int d;
        fork
            monitor_loop();
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_done",  33'(DONE),  33'd0);
        chk("rst_error", 33'(ERROR), 33'd0);
        chk("rst_busy",  33'(busy),  33'd0);
        chk("rst_data",  33'(data),  33'd0);
        chk("rst_state", 33'(dbg_state), 33'(S_IDLE));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Valid frame addr 0x00 cmd 0x45
        read = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b0, 32'hBA45FF00});
        last_good = 32'hBA45FF00;
        send_frame(32'hBA45FF00, 32, 1'b1, 200);
        chk("data_frame1", 33'(data), 33'(last_good));

        // Bad inverse command byte
`ifdef IR_NEC_CHECK_EN
        exp_q.push_back({1'b1, last_good});
`else
        exp_q.push_back({1'b0, 32'hBB45FF00});
        last_good = 32'hBB45FF00;
`endif
        send_frame(32'hBB45FF00, 32, 1'b1, 200);
        chk("data_frame2", 33'(data), 33'(last_good));

        // Short leader mark (6000 us); read drops mid-mark without aborting
        exp_q.push_back({1'b1, last_good});
        ir_in = 1'b0;
        repeat (300) @(negedge clk);
        read = 1'b0;
        repeat (300) @(negedge clk);
        ir_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("short_lead_err_latency", 33'(ERROR), 33'd1);
        @(negedge clk);
        chk("short_lead_err_one_cycle", 33'(ERROR), 33'd0);
        chk("short_lead_back_idle", 33'(dbg_state), 33'(S_IDLE));

        // Line held low 13000 us: timeout at 12000 us with no edge
        read = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b1, last_good});
        c0 = cyc;
        n0 = evt_count;
        drive(1'b0, 1100);
        chk("timeout_busy_before", 33'(busy), 33'd1);
        chk("timeout_not_early", 33'(evt_count), 33'(n0));
        drive(1'b0, 200);
        drive(1'b1, 20);
        d = last_evt_cyc - c0;
        chk("timeout_position", 33'((d >= 1200) && (d <= 1210)), 33'd1);
        read = 1'b0;
        repeat (3) @(negedge clk);

        // Reset after bit 10, then a clean frame
        read = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(32'hBA45FF00, 10, 1'b0, 20);
        chk("mid_frame_busy", 33'(busy), 33'd1);
        reset = 1'b0;
        #1;
        chk("midrst_done",  33'(DONE),  33'd0);
        chk("midrst_error", 33'(ERROR), 33'd0);
        chk("midrst_busy",  33'(busy),  33'd0);
        chk("midrst_data",  33'(data),  33'd0);
        last_good = 32'h0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        exp_q.push_back({1'b0, 32'h12ED08F7});
        last_good = 32'h12ED08F7;
        send_frame(32'h12ED08F7, 32, 1'b1, 200);
        chk("data_after_reset", 33'(data), 33'(last_good));

        // read low: full frame ignored
        read = 1'b0;
        repeat (3) @(negedge clk);
        busy_seen = 1'b0;
        watch_busy = 1'b1;
        n0 = evt_count;
        send_frame(32'hBA45FF00, 32, 1'b1, 200);
        watch_busy = 1'b0;
        chk("unarmed_busy_low", 33'(busy_seen), 33'd0);
        chk("unarmed_no_event", 33'(evt_count), 33'(n0));
        chk("unarmed_data_hold", 33'(data), 33'(last_good));

        // Final report
        repeat (20) @(negedge clk);
        chk("scoreboard_drained", 33'(exp_q.size()), 33'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
